// File: rtl/adc_capture_buf.sv
// Multi-lane ADC stream capture engine: arm/trigger, decimate and write a
// fixed-length record of each enabled lane into its own BRAM write port.
module adc_capture_buf #(
  parameter int unsigned NCHAN       = 2,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned DECIM_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NCHAN-1:0]                s_valid,
  input  logic [NCHAN*DATA_WIDTH-1:0]     s_data,
  output logic [NCHAN-1:0]                s_ready,
  input  logic [NCHAN-1:0]                chan_mask,
  input  logic [ADDR_WIDTH:0]             length,
  input  logic [DECIM_WIDTH-1:0]          decim,
  input  logic                            trig_mode,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            trig,
  output logic [NCHAN-1:0]                bram_en,
  output logic [NCHAN*DATA_WIDTH/8-1:0]   bram_we,
  output logic [NCHAN*ADDR_WIDTH-1:0]     bram_addr,
  output logic [NCHAN*DATA_WIDTH-1:0]     bram_din,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH:0]             count,
  output logic                            skew_err
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] FULL_LEN = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t                 state;
  logic [NCHAN-1:0]       mask_q;
  logic [ADDR_WIDTH:0]    len_q;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [DECIM_WIDTH-1:0] dcnt;
  logic                   trig_mode_q;

  logic [ADDR_WIDTH:0]    len_eff;
  logic [NCHAN-1:0]       valid_en;
  logic                   qualified;
  logic                   skew;

  // Zero or anything at/above the BRAM depth both mean a full-depth record.
  assign len_eff   = (length == '0 || length[ADDR_WIDTH]) ? FULL_LEN : length;
  assign valid_en  = s_valid & mask_q;
  assign qualified = (valid_en == mask_q);
  assign skew      = (valid_en != '0) && (valid_en != mask_q);

  // ADC streams cannot be stalled; ready only drops while held in reset.
  assign s_ready = {NCHAN{~rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      len_q       <= '0;
      decim_q     <= '0;
      dcnt        <= '0;
      trig_mode_q <= 1'b0;
      bram_en     <= '0;
      bram_we     <= '0;
      bram_addr   <= '0;
      bram_din    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      skew_err    <= 1'b0;
    end else begin
      bram_en   <= '0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_din  <= '0;

      if ((state == ARMED || state == CAPTURE) && skew)
        skew_err <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start && !stop) begin
            mask_q      <= chan_mask;
            len_q       <= len_eff;
            decim_q     <= decim;
            trig_mode_q <= trig_mode;
            count       <= '0;
            dcnt        <= '0;
            skew_err    <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            state       <= ARMED;
          end
        end
        ARMED: begin
          if (stop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (!trig_mode_q || trig) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (stop || count == len_q || mask_q == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (qualified) begin
            dcnt <= (dcnt == decim_q) ? '0 : dcnt + DECIM_WIDTH'(1);
            if (dcnt == '0) begin
              for (int unsigned i = 0; i < NCHAN; i++) begin
                if (mask_q[i]) begin
                  bram_en[i]                           <= 1'b1;
                  bram_we[i*BW +: BW]                  <= '1;
                  bram_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <= count[ADDR_WIDTH-1:0];
                  bram_din[i*DATA_WIDTH +: DATA_WIDTH] <= s_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
              end
              count <= count + (ADDR_WIDTH+1)'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
